// File: rtl/tmds_encoder.sv
// Single-lane TMDS 8b/10b encoder, 2-stage pipeline after the input register, 1 symbol/clock.
// Optional TERC4 data-island coding is enabled by defining TMDS_ENC_TERC4_EN.
module tmds_encoder #(
    parameter logic [9:0] CTRL_RST = 10'b1101010100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       de,
    input  logic       c0,
    input  logic       c1,
    input  logic [7:0] din,
`ifdef TMDS_ENC_TERC4_EN
    input  logic       island,
    input  logic [3:0] aux,
`endif
    output logic [9:0] dout
);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    function automatic logic [9:0] ctrl_code(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'b1101010100;
            2'b01:   s = 10'b0010101011;
            2'b10:   s = 10'b0101010100;
            default: s = 10'b1010101011;
        endcase
        return s;
    endfunction

`ifdef TMDS_ENC_TERC4_EN
    function automatic logic [9:0] terc4_code(input logic [3:0] a);
        logic [9:0] s;
        case (a)
            4'h0:    s = 10'b1010011100;
            4'h1:    s = 10'b1001100011;
            4'h2:    s = 10'b1011100100;
            4'h3:    s = 10'b1011100010;
            4'h4:    s = 10'b0101110001;
            4'h5:    s = 10'b0100011110;
            4'h6:    s = 10'b0110001110;
            4'h7:    s = 10'b0100111100;
            4'h8:    s = 10'b1011001100;
            4'h9:    s = 10'b0100111001;
            4'hA:    s = 10'b0110011100;
            4'hB:    s = 10'b1011000110;
            4'hC:    s = 10'b1010001110;
            4'hD:    s = 10'b1001110001;
            4'hE:    s = 10'b0101100011;
            default: s = 10'b1011000011;
        endcase
        return s;
    endfunction
`endif

    logic [7:0]        s1_din;
    logic              s1_de;
    logic [1:0]        s1_c;
    logic [3:0]        s1_n1d;
    logic [8:0]        qm_c;
    logic [8:0]        s2_qm;
    logic              s2_de;
    logic [1:0]        s2_c;
    logic signed [4:0] cnt;
    logic signed [4:0] cnt_nx;
    logic signed [4:0] bal;
    logic [3:0]        n1q;
    logic [9:0]        dout_nx;
    logic              use_xnor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_din <= '0;
            s1_de  <= 1'b0;
            s1_c   <= '0;
            s1_n1d <= '0;
        end else begin
            s1_din <= din;
            s1_de  <= de;
            s1_c   <= {c1, c0};
            s1_n1d <= popcount8(din);
        end
    end

    // Transition-minimising stage: XNOR chain when the byte is ones-heavy.
    always_comb begin
        use_xnor = (s1_n1d > 4'd4) || ((s1_n1d == 4'd4) && !s1_din[0]);
        qm_c     = '0;
        qm_c[0]  = s1_din[0];
        for (int i = 1; i < 8; i++) begin
            qm_c[i] = use_xnor ? ~(qm_c[i-1] ^ s1_din[i]) : (qm_c[i-1] ^ s1_din[i]);
        end
        qm_c[8] = ~use_xnor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_qm <= '0;
            s2_de <= 1'b0;
            s2_c  <= '0;
        end else begin
            s2_qm <= qm_c;
            s2_de <= s1_de;
            s2_c  <= s1_c;
        end
    end

`ifdef TMDS_ENC_TERC4_EN
    logic       s1_island;
    logic [3:0] s1_aux;
    logic       s2_island;
    logic [3:0] s2_aux;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_island <= 1'b0;
            s1_aux    <= '0;
            s2_island <= 1'b0;
            s2_aux    <= '0;
        end else begin
            s1_island <= island;
            s1_aux    <= aux;
            s2_island <= s1_island;
            s2_aux    <= s1_aux;
        end
    end
`endif

    // bal = n1q - n0q = 2*n1q - 8; modulo-32 arithmetic keeps n1q=8 correct.
    always_comb begin
        n1q     = popcount8(s2_qm[7:0]);
        bal     = $signed({n1q, 1'b0}) - 5'sd8;
        cnt_nx  = cnt;
        dout_nx = ctrl_code(s2_c);
        if (s2_de) begin
            if ((cnt == 5'sd0) || (bal == 5'sd0)) begin
                dout_nx = {~s2_qm[8], s2_qm[8], s2_qm[8] ? s2_qm[7:0] : ~s2_qm[7:0]};
                cnt_nx  = cnt + (s2_qm[8] ? bal : -bal);
            end else if (((cnt > 5'sd0) && (bal > 5'sd0)) ||
                         ((cnt < 5'sd0) && (bal < 5'sd0))) begin
                dout_nx = {1'b1, s2_qm[8], ~s2_qm[7:0]};
                cnt_nx  = cnt + (s2_qm[8] ? 5'sd2 : 5'sd0) - bal;
            end else begin
                dout_nx = {1'b0, s2_qm[8], s2_qm[7:0]};
                cnt_nx  = cnt + bal - (s2_qm[8] ? 5'sd0 : 5'sd2);
            end
        end else begin
            cnt_nx = '0;
`ifdef TMDS_ENC_TERC4_EN
            if (s2_island) dout_nx = terc4_code(s2_aux);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= CTRL_RST;
            cnt  <= '0;
        end else begin
            dout <= dout_nx;
            cnt  <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: directed control/data vectors, a random line against
// a behavioural model, and mid-line reset. TERC4 vectors only when TMDS_ENC_TERC4_EN is set.
module tb_tmds_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       de = 1'b0;
    logic       c0 = 1'b0;
    logic       c1 = 1'b0;
    logic [7:0] din = '0;
    logic [9:0] dout;
`ifdef TMDS_ENC_TERC4_EN
    logic       island = 1'b0;
    logic [3:0] aux = '0;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [9:0] exp;
        string      name;
        bit         trk;
        bit         start;
    } sb_t;

    sb_t        sb[$];
    logic       issued = 1'b0;
    logic [2:0] vp;
    int         run_sum = 0;
    int         run_max = 0;

    tmds_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .de    (de),
        .c0    (c0),
        .c1    (c1),
        .din   (din),
`ifdef TMDS_ENC_TERC4_EN
        .island(island),
        .aux   (aux),
`endif
        .dout  (dout)
    );

    always #5 clk = ~clk;

    // Tracks which edges sampled a checked input; dout for it appears two edges later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) vp <= '0;
        else        vp <= {vp[1:0], issued};
    end

    always @(negedge clk) begin
        if (rst_n && vp[2]) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: dout=%h with no expected value queued", dout);
            end else begin
                sb_t e;
                int  ones;
                e = sb.pop_front();
                if (dout !== e.exp) begin
                    errors++;
                    $display("FAIL %s: dout=%h expected=%h", e.name, dout, e.exp);
                end
                if (e.trk) begin
                    if (e.start) begin
                        run_sum = 0;
                        run_max = 0;
                    end
                    ones = $countones(dout);
                    run_sum += 2 * ones - 10;
                    if (run_sum > run_max)  run_max = run_sum;
                    if (-run_sum > run_max) run_max = -run_sum;
                end
            end
        end
    end

    function automatic logic [9:0] tmds_ref(input logic [7:0] d, input int cnt_in,
                                            output int cnt_out);
        int         n1, n1q, n0q;
        bit         xn;
        logic [8:0] q;
        logic [9:0] sym;
        n1   = $countones(d);
        xn   = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !xn;
        n1q  = $countones(q[7:0]);
        n0q  = 8 - n1q;
        if (cnt_in == 0 || n1q == n0q) begin
            sym     = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            cnt_out = cnt_in + (q[8] ? (n1q - n0q) : (n0q - n1q));
        end else if ((cnt_in > 0 && n1q > n0q) || (cnt_in < 0 && n0q > n1q)) begin
            sym     = {1'b1, q[8], ~q[7:0]};
            cnt_out = cnt_in + 2 * int'(q[8]) + (n0q - n1q);
        end else begin
            sym     = {1'b0, q[8], q[7:0]};
            cnt_out = cnt_in + (n1q - n0q) - 2 * (q[8] ? 0 : 1);
        end
        return sym;
    endfunction

    task automatic send(input logic d_e, input logic [1:0] c, input logic [7:0] d,
                        input logic [9:0] exp, input string nm,
                        input bit trk = 1'b0, input bit start = 1'b0);
        sb_t e;
        @(negedge clk);
        de      = d_e;
        {c1, c0} = c;
        din     = d;
        issued  = 1'b1;
        e.exp   = exp;
        e.name  = nm;
        e.trk   = trk;
        e.start = start;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            de       = 1'b0;
            {c1, c0} = 2'b00;
            issued   = 1'b0;
        end
    endtask

    task automatic check_now(input string nm, input logic [9:0] exp);
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL %s: dout=%h expected=%h", nm, dout, exp);
        end
    endtask

    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_now("reset_hold", 10'h354);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int         mcnt;
        int         ncnt;
        logic [7:0] r;
        logic [9:0] e;

        // Test 1: reset held and released with control token 00.
        #1 rst_n = 1'b0;
        #1 check_now("reset_async", 10'h354);
        hold_reset(3);
        send(1'b0, 2'b00, 8'h00, 10'h354, "ctrl00_after_rst");
        send(1'b0, 2'b00, 8'h5A, 10'h354, "ctrl00_din_ignored");

        // Test 2: remaining control tokens.
        send(1'b0, 2'b01, 8'h00, 10'h0AB, "ctrl01");
        send(1'b0, 2'b10, 8'h00, 10'h154, "ctrl10");
        send(1'b0, 2'b11, 8'h00, 10'h2AB, "ctrl11");

        // Test 3: zeros from cnt=0 exercise cases A, B, C.
        send(1'b1, 2'b00, 8'h00, 10'h100, "zero_caseA");
        send(1'b1, 2'b00, 8'h00, 10'h3FF, "zero_caseB");
        send(1'b1, 2'b00, 8'h00, 10'h100, "zero_caseC");
        send(1'b0, 2'b00, 8'hFF, 10'h354, "ctrl_gap1");

        // Test 4: 0xFF then control must clear cnt.
        send(1'b1, 2'b00, 8'hFF, 10'h200, "ff_caseA");
        send(1'b0, 2'b00, 8'h00, 10'h354, "ctrl_gap2");
        send(1'b1, 2'b00, 8'h00, 10'h100, "zero_after_ctrl");
        send(1'b0, 2'b00, 8'h00, 10'h354, "ctrl_gap3");

        // 0x01 stays XOR-coded to all ones, then inverts once cnt is positive.
        send(1'b1, 2'b00, 8'h01, 10'h1FF, "one_caseA");
        send(1'b1, 2'b00, 8'h01, 10'h300, "one_caseB");
        send(1'b0, 2'b01, 8'h00, 10'h0AB, "ctrl_gap4");

        // Test 5: one random 1280-pixel line against the model.
        mcnt = 0;
        for (int i = 0; i < 1280; i++) begin
            r = 8'($urandom_range(0, 255));
            e = tmds_ref(r, mcnt, ncnt);
            mcnt = ncnt;
            send(1'b1, 2'b00, r, e, "rand_line", 1'b1, (i == 0));
        end
        send(1'b0, 2'b00, 8'h00, 10'h354, "ctrl_eol");
        send(1'b0, 2'b00, 8'h00, 10'h354, "ctrl_eol2");

        // Test 6: reset mid-line with cnt != 0.
        send(1'b1, 2'b00, 8'h00, 10'h100, "pre_rst_caseA");
        send(1'b1, 2'b00, 8'h00, 10'h3FF, "pre_rst_caseB");
        send(1'b1, 2'b00, 8'h00, 10'h100, "pre_rst_inflight");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        issued = 1'b0;
        de     = 1'b0;
        #1 check_now("midline_rst_async", 10'h354);
        sb.delete();
        hold_reset(2);
        send(1'b1, 2'b00, 8'h00, 10'h100, "post_rst_cnt0");
`ifdef TMDS_ENC_TERC4_EN
        @(negedge clk);
        island = 1'b1;
        aux    = 4'h0;
        sb.push_back('{exp: 10'b1010011100, name: "terc4_0", trk: 1'b0, start: 1'b0});
        de = 1'b0; {c1, c0} = 2'b00; issued = 1'b1;
        @(negedge clk);
        aux = 4'h5;
        sb.push_back('{exp: 10'b0100011110, name: "terc4_5", trk: 1'b0, start: 1'b0});
        @(negedge clk);
        island = 1'b0;
        de = 1'b1; din = 8'h00;
        sb.push_back('{exp: 10'h100, name: "after_island", trk: 1'b0, start: 1'b0});
`endif
        idle(4);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: pending=%0d expected=0", sb.size());
        end
        checks++;
        if (run_max > 18) begin
            errors++;
            $display("FAIL line_disparity: max=%0d limit=18", run_max);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: sim time exceeded bound");
        $fatal(1);
    end

endmodule
